kv_line_fill: RTL

Line-refill engine between the KV data cache and the word-wide backing memory bus. Accepts one cache-line miss request, issues LINE_SIZE word reads to memory (pipelined, in-order responses), assembles the words into a line buffer, and presents the complete line to the cache's fetch port. Handles one miss at a time; the next request is accepted only after the current line is consumed.

---
 rtl/kv_line_fill.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/kv_line_fill.sv
// kv_line_fill: line-refill engine between the KV data cache and the
// word-wide backing memory bus. Takes one miss, issues LINE_SIZE pipelined
// word reads, assembles the in-order responses into a line buffer and holds
// the finished line until the cache consumes it.
//
// Build option: define KV_LINE_FILL_CWF_EN for critical-word-first issue
// order (beats start at the requested word and wrap through the line).
// Without it, beats are issued in ascending offset order from word 0.
// The buffer layout presented on o_line_data is identical in both builds.
module kv_line_fill #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_SIZE  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_valid,
   input  logic                  i_mem_ready,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   input  logic                  i_mem_rvalid,
   output logic [DATA_WIDTH-1:0] o_line_data [LINE_SIZE],
   output logic [ADDR_WIDTH-1:0] o_line_addr,
   output logic                  o_line_valid,
   input  logic                  i_line_ready
);

   localparam int OFF_W = $clog2(LINE_SIZE);
   localparam int CNT_W = OFF_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_SIZE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [OFF_W-1:0]       start_q, start_d;
   logic [CNT_W-1:0]       issue_q, issue_d;
   logic [CNT_W-1:0]       recv_q, recv_d;
   logic [DATA_WIDTH-1:0]  buf_q [LINE_SIZE];
   logic [DATA_WIDTH-1:0]  buf_d [LINE_SIZE];

   logic                   mem_valid_s;
   logic                   addr_hs_s;
   logic                   rd_acc_s;
   logic [OFF_W-1:0]       req_start_s;
   logic [OFF_W-1:0]       beat_off_s;
   logic [OFF_W-1:0]       wr_idx_s;

   // Handshake qualification and wrapping offset arithmetic shared by all processes.
   always_comb begin
`ifdef KV_LINE_FILL_CWF_EN
      req_start_s = i_req_addr[OFF_W-1:0];
`else
      req_start_s = {OFF_W{1'b0}};
`endif
      mem_valid_s = (state_q == ST_FILL) && (issue_q < CNT_FULL);
      addr_hs_s   = mem_valid_s && i_mem_ready;
      // A response is only legitimate for a read already issued, including one issued this cycle.
      rd_acc_s    = (state_q == ST_FILL) && i_mem_rvalid &&
                    ((recv_q < issue_q) || (addr_hs_s && (recv_q == issue_q)));
      beat_off_s  = start_q + issue_q[OFF_W-1:0];
      wr_idx_s    = start_q + recv_q[OFF_W-1:0];
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: accept, fill until every beat has returned, hold until consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) state_d = ST_FILL;
            else             state_d = ST_IDLE;
         end
         ST_FILL: begin
            if (rd_acc_s && (recv_q == CNT_LAST)) state_d = ST_DONE;
            else                                  state_d = ST_FILL;
         end
         ST_DONE: begin
            if (i_line_ready) state_d = ST_IDLE;
            else              state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state: latch the request, count issued/returned beats, fill the buffer.
   always_comb begin
      addr_d  = addr_q;
      start_d = start_q;
      issue_d = issue_q;
      recv_d  = recv_q;
      buf_d   = buf_q;
      if ((state_q == ST_IDLE) && i_req_valid) begin
         addr_d  = i_req_addr;
         start_d = req_start_s;
         issue_d = {CNT_W{1'b0}};
         recv_d  = {CNT_W{1'b0}};
      end else begin
         if (addr_hs_s) issue_d = issue_q + CNT_ONE;
         else           issue_d = issue_q;
         if (rd_acc_s) begin
            buf_d[wr_idx_s] = i_mem_rdata;
            recv_d          = recv_q + CNT_ONE;
         end else begin
            recv_d = recv_q;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         addr_q  <= {ADDR_WIDTH{1'b0}};
         start_q <= {OFF_W{1'b0}};
         issue_q <= {CNT_W{1'b0}};
         recv_q  <= {CNT_W{1'b0}};
         for (int i = 0; i < LINE_SIZE; i++) begin
            buf_q[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         addr_q  <= addr_d;
         start_q <= start_d;
         issue_q <= issue_d;
         recv_q  <= recv_d;
         for (int i = 0; i < LINE_SIZE; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   // Output decode, purely from registered state so no input reaches an output combinationally.
   always_comb begin
      o_req_ready  = (state_q == ST_IDLE);
      o_mem_valid  = mem_valid_s;
      o_mem_addr   = {addr_q[ADDR_WIDTH-1:OFF_W], beat_off_s};
      o_line_valid = (state_q == ST_DONE);
      o_line_addr  = addr_q;
      o_line_data  = buf_q;
   end

endmodule
